// File: rtl/data_mem_ctrl.sv
// Byte-wide data memory with a fixed-latency request/complete handshake.
// Illegal requests complete immediately with err and leave memory and rdata untouched.
module data_mem_ctrl #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       memread,
   input  logic       memwrite,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0]  DEPTH_LIM = 9'(DEPTH);
   localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic [AW-1:0] cap_addr;
   logic [7:0]    cap_wdata;
   logic          cap_write;
   logic [7:0]    mem [DEPTH];
   logic          req;
   logic          legal;

   always_comb begin
      req   = memread | memwrite;
      legal = (memread ^ memwrite) && ({1'b0, addr} < DEPTH_LIM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_write <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req) begin
                  busy      <= 1'b1;
                  cap_addr  <= addr[AW-1:0];
                  cap_wdata <= wdata;
                  cap_write <= memwrite;
                  if (legal) begin
                     state <= S_WAIT;
                     cnt   <= CNT_LOAD;
                  end else begin
                     // Rejected request skips WAIT and reports err with its done pulse
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  if (cap_write) mem[cap_addr] <= cap_wdata;
                  else           rdata         <= mem[cap_addr];
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a reference model pushes expected completions,
// each feature task pops and compares them when the DUT pulses done.
module tb_data_mem_ctrl;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned LAT   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       memread;
   logic       memwrite;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       busy;
   logic       done;
   logic       err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       e_err;
      logic [7:0] e_rdata;
      int         e_cyc;
      int         e_busy;
   } exp_t;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
   } req_t;

   exp_t       sb[$];
   logic [7:0] mdl_mem [DEPTH];
   logic [7:0] mdl_rdata;

   data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .memread  (memread),
      .memwrite (memwrite),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      foreach (mdl_mem[i]) mdl_mem[i] = '0;
      mdl_rdata = '0;
   endtask

   task automatic push_exp(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
      exp_t x;
      logic legal;
      legal = (rd ^ wr) && (32'(a) < DEPTH);
      if (legal && rd) mdl_rdata = mdl_mem[a[5:0]];
      if (legal && wr) mdl_mem[a[5:0]] = d;
      x.e_err   = !legal;
      x.e_rdata = mdl_rdata;
      x.e_cyc   = legal ? int'(LAT) : 0;
      x.e_busy  = legal ? int'(LAT) + 1 : 1;
      sb.push_back(x);
   endtask

   // Drives one request for a single edge, then observes until done (bounded).
   task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                         output int cyc, output int bcnt, output logic got_err,
                         output logic [7:0] got_rdata, output logic [1:0] tail);
      @(negedge clk);
      memread = rd; memwrite = wr; addr = a; wdata = d;
      @(negedge clk);
      memread = 1'b0; memwrite = 1'b0;
      cyc  = 0;
      bcnt = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
      if (busy === 1'b1) bcnt++;
      got_err   = err;
      got_rdata = rdata;
      @(negedge clk);
      tail = {busy, done};
   endtask

   task automatic apply_reset();
      memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic run_reqs_check(input string tag, input req_t reqs[$]);
      int cyc, bcnt; logic e; logic [7:0] r; logic [1:0] tl; exp_t x;
      foreach (reqs[i]) begin
         push_exp(reqs[i].rd, reqs[i].wr, reqs[i].a, reqs[i].d);
         access(reqs[i].rd, reqs[i].wr, reqs[i].a, reqs[i].d, cyc, bcnt, e, r, tl);
         x = sb.pop_front();
         checks++;
         if (cyc !== x.e_cyc) begin failures++; $display("FAIL %s[%0d] done_latency: got %0d want %0d", tag, i, cyc, x.e_cyc); end
         checks++;
         if (bcnt !== x.e_busy) begin failures++; $display("FAIL %s[%0d] busy_cycles: got %0d want %0d", tag, i, bcnt, x.e_busy); end
         checks++;
         if (e !== x.e_err) begin failures++; $display("FAIL %s[%0d] err: got %b want %b", tag, i, e, x.e_err); end
         checks++;
         if (r !== x.e_rdata) begin failures++; $display("FAIL %s[%0d] rdata: got %h want %h", tag, i, r, x.e_rdata); end
         checks++;
         if (tl !== 2'b00) begin failures++; $display("FAIL %s[%0d] busy_done_after: got %b want 00", tag, i, tl); end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++; if (busy  !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", busy); end
      checks++; if (done  !== 1'b0) begin failures++; $display("FAIL reset done: got %b want 0", done); end
      checks++; if (err   !== 1'b0) begin failures++; $display("FAIL reset err: got %b want 0", err); end
      checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset rdata: got %h want 00", rdata); end
   endtask

   task automatic test_write_read();
      req_t q[$];
      q.push_back('{1'b0, 1'b1, 8'h05, 8'hA5});
      q.push_back('{1'b1, 1'b0, 8'h05, 8'h00});
      run_reqs_check("write_read", q);
   endtask

   task automatic test_untouched_read();
      req_t q[$];
      q.push_back('{1'b1, 1'b0, 8'h10, 8'h00});
      run_reqs_check("untouched_read", q);
   endtask

   task automatic test_illegal_both();
      req_t q[$];
      q.push_back('{1'b0, 1'b1, 8'h02, 8'h77});
      q.push_back('{1'b1, 1'b0, 8'h05, 8'h00});
      q.push_back('{1'b1, 1'b1, 8'h02, 8'h99});
      q.push_back('{1'b1, 1'b0, 8'h02, 8'h00});
      run_reqs_check("illegal_both", q);
   endtask

   task automatic test_out_of_range();
      req_t q[$];
      q.push_back('{1'b0, 1'b1, 8'h40, 8'h5A});
      q.push_back('{1'b0, 1'b1, 8'h3F, 8'hC3});
      q.push_back('{1'b1, 1'b0, 8'h3F, 8'h00});
      q.push_back('{1'b1, 1'b0, 8'h00, 8'h00});
      q.push_back('{1'b1, 1'b0, 8'hFF, 8'h00});
      run_reqs_check("out_of_range", q);
   endtask

   task automatic test_reset_during_wait();
      req_t q[$];
      int dcnt;
      @(negedge clk);
      memwrite = 1'b1; addr = 8'h07; wdata = 8'h3C;
      @(negedge clk);
      memwrite = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy  !== 1'b0) begin failures++; $display("FAIL rst_wait busy: got %b want 0", busy); end
      checks++; if (done  !== 1'b0) begin failures++; $display("FAIL rst_wait done: got %b want 0", done); end
      checks++; if (err   !== 1'b0) begin failures++; $display("FAIL rst_wait err: got %b want 0", err); end
      checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL rst_wait rdata: got %h want 00", rdata); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      dcnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      checks++; if (dcnt !== 0) begin failures++; $display("FAIL rst_wait done_after_release: got %0d pulses want 0", dcnt); end
      q.push_back('{1'b1, 1'b0, 8'h07, 8'h00});
      q.push_back('{1'b1, 1'b0, 8'h3F, 8'h00});
      run_reqs_check("rst_wait_readback", q);
   endtask

   task automatic test_ignore_during_busy();
      req_t q[$];
      int cyc; exp_t x;
      q.push_back('{1'b0, 1'b1, 8'h11, 8'h22});
      q.push_back('{1'b0, 1'b1, 8'h12, 8'h33});
      run_reqs_check("ignore_setup", q);
      push_exp(1'b1, 1'b0, 8'h11, 8'h00);
      @(negedge clk);
      memread = 1'b1; addr = 8'h11;
      @(negedge clk);
      memread = 1'b0; memwrite = 1'b1; addr = 8'h12; wdata = 8'hEE;
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         memwrite = ~memwrite; memread = 1'b1;
      end
      memread = 1'b0; memwrite = 1'b0;
      x = sb.pop_front();
      checks++; if (cyc !== x.e_cyc) begin failures++; $display("FAIL ignore latency: got %0d want %0d", cyc, x.e_cyc); end
      checks++; if (rdata !== x.e_rdata) begin failures++; $display("FAIL ignore rdata: got %h want %h", rdata, x.e_rdata); end
      @(negedge clk);
      q.delete();
      q.push_back('{1'b1, 1'b0, 8'h12, 8'h00});
      q.push_back('{1'b1, 1'b0, 8'h11, 8'h00});
      run_reqs_check("ignore_readback", q);
   endtask

   task automatic test_back_to_back();
      int idx[$];
      int drain;
      logic [7:0] want;
      want = mdl_mem[6'h11];
      @(negedge clk);
      memread = 1'b1; addr = 8'h11;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            idx.push_back(i);
            checks++;
            if (rdata !== want) begin failures++; $display("FAIL b2b_read rdata@%0d: got %h want %h", i, rdata, want); end
         end
      end
      memread = 1'b0;
      checks++; if (idx.size() !== 3) begin failures++; $display("FAIL b2b_read pulses: got %0d want 3", idx.size()); end
      else begin
         checks++;
         if (idx[1] - idx[0] !== int'(LAT) + 2) begin failures++; $display("FAIL b2b_read gap: got %0d want %0d", idx[1] - idx[0], LAT + 2); end
      end
      drain = 0;
      while (busy === 1'b1 && drain < 20) begin @(negedge clk); drain++; end
      idx.delete();
      @(negedge clk);
      memread = 1'b1; memwrite = 1'b1; addr = 8'h02;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            idx.push_back(i);
            checks++;
            if (err !== 1'b1) begin failures++; $display("FAIL b2b_illegal err@%0d: got %b want 1", i, err); end
         end
      end
      memread = 1'b0; memwrite = 1'b0;
      checks++; if (idx.size() !== 3) begin failures++; $display("FAIL b2b_illegal pulses: got %0d want 3", idx.size()); end
      else begin
         checks++;
         if (idx[1] - idx[0] !== 2) begin failures++; $display("FAIL b2b_illegal gap: got %0d want 2", idx[1] - idx[0]); end
      end
      drain = 0;
      while (busy === 1'b1 && drain < 20) begin @(negedge clk); drain++; end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b drain busy: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_untouched_read();
      test_illegal_both();
      test_out_of_range();
      test_reset_during_wait();
      test_ignore_during_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 8-bit storage locations (1..256).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles from request acceptance to access (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port memread  input  1  read request from control unit.
REQ-006 SHALL have port memwrite  input  1  write request from control unit.
REQ-007 SHALL have port addr  input  8  byte address of request.
REQ-008 SHALL have port wdata  input  8  store data.
REQ-009 SHALL have port rdata  output  8  load data, valid while done=1 on a read, held afterwards.
REQ-010 SHALL have port busy  output  1  high while a request is in flight (WAIT and DONE states).
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  qualifies done: request rejected, no access performed.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE; all outputs registered.
REQ-014 SHALL accept a request only in IDLE, at a rising edge where memread=1 or memwrite=1; addr and wdata captured at that edge (edge E0).
REQ-015 SHALL treat a request as legal when exactly one of memread/memwrite is 1 and addr < DEPTH.
REQ-016 Legal request: SHALL go IDLE->WAIT at E0, with a down-counter loaded with LATENCY-1.
REQ-017 In WAIT, SHALL decrement the counter each edge; at the edge where counter=0 (E0+LATENCY), SHALL perform the access and go to DONE.
REQ-018 Read: SHALL load rdata from mem[addr] at E0+LATENCY; rdata then holds until the next legal read completes.
REQ-019 Write: SHALL update mem[addr] with captured wdata at E0+LATENCY; rdata unchanged.
REQ-020 Illegal request (both strobes high, or addr >= DEPTH): SHALL go IDLE->DONE at E0 with err=1, no memory or rdata change.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-022 err SHALL be 1 only during DONE of an illegal request, else 0.
REQ-023 Strobe, addr and wdata changes while busy=1 SHALL be ignored; no queuing of requests.
REQ-024 Back-to-back: earliest next acceptance SHALL be edge E0+LATENCY+2 (legal) or E0+2 (illegal).
REQ-025 Strobes held high continuously SHALL cause a new acceptance at each IDLE edge (repeat access).
REQ-026 Reads of addresses not yet written SHALL return 8'h00.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force state IDLE, counter 0, busy=0, done=0, err=0, rdata=8'h00, all mem locations 8'h00.
REQ-028 Reset during WAIT SHALL abort the request: no write is committed and no done pulse occurs after release.
REQ-029 First acceptance after release SHALL be at the first rising edge with rst_n=1 and a strobe high.

Verification
REQ-030 Write addr=8'h05 wdata=8'hA5, LATENCY=2 -> busy high 3 cycles, done=1 err=0 in cycle after E0+2; then read addr 8'h05 -> rdata=8'hA5 with done.
REQ-031 Read untouched addr=8'h10 after reset -> done=1, err=0, rdata=8'h00.
REQ-032 memread=memwrite=1, addr=8'h02 -> done=err=1 in cycle after E0, mem[2] and rdata unchanged.
REQ-033 Write addr=8'h40 (DEPTH=64) -> done=err=1, no write; read 8'h3F works normally.
REQ-034 Write 8'h3C to addr 8'h07, assert rst_n=0 during WAIT -> outputs zero at once, no done; later read 8'h07 -> 8'h00.
REQ-035 Change addr and toggle memwrite during WAIT of a read -> rdata reflects the originally captured address only.
